// File: rtl/bus_transfer_if.sv
// bus_transfer_if: request handshake and register-bank bus between control unit and transfer controller
interface bus_transfer_if #(
   parameter int NUM_REGS = 4,
   parameter int SEL_W    = 2,
   parameter int DATA_W   = 8
);
   logic                         start;
   logic [1:0]                   op;
   logic [SEL_W-1:0]             src_sel;
   logic [SEL_W-1:0]             dst_sel;
   logic [DATA_W-1:0]            imm;
   logic [NUM_REGS*DATA_W-1:0]   reg_values;
   logic [NUM_REGS-1:0]          read_data;
   logic [NUM_REGS-1:0]          write_data;
   logic [DATA_W-1:0]            data_bus;
   logic [DATA_W-1:0]            result;
   logic                         busy;
   logic                         done;
   logic                         err;
   modport master (
      input  start, op, src_sel, dst_sel, imm, reg_values,
      output read_data, write_data, data_bus, result, busy, done, err
   );
   modport slave (
      output start, op, src_sel, dst_sel, imm, reg_values,
      input  read_data, write_data, data_bus, result, busy, done, err
   );
endinterface

// File: rtl/bus_transfer_controller.sv
// bus_transfer_controller: sequences one-hot register strobes for MOV, LOAD and READ transfers
module bus_transfer_controller #(
   parameter int NUM_REGS = 4,
   parameter int SEL_W    = 2,
   parameter int DATA_W   = 8
) (
   input  logic           clock,
   input  logic           reset,
   bus_transfer_if.master bus
);
   typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} state_t;
   state_t              state;
   logic [1:0]          op_q;
   logic [SEL_W-1:0]    src_q, dst_q;
   logic [DATA_W-1:0]   xfer, slice;
   logic                src_ok, dst_ok, ok;
   assign slice    = bus.reg_values[int'(src_q)*DATA_W +: DATA_W];
   assign src_ok   = int'(bus.src_sel) < NUM_REGS;
   assign dst_ok   = int'(bus.dst_sel) < NUM_REGS;
   assign bus.busy = state != IDLE;
   always_comb ok = bus.op == 2'b00 ? src_ok && dst_ok :
                    bus.op == 2'b01 ? dst_ok :
                    bus.op == 2'b10 ? src_ok : 1'b0;
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         op_q           <= '0;
         src_q          <= '0;
         dst_q          <= '0;
         xfer           <= '0;
         bus.read_data  <= '0;
         bus.write_data <= '0;
         bus.data_bus   <= '0;
         bus.result     <= '0;
         bus.done       <= 1'b0;
         bus.err        <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               op_q  <= bus.op;
               src_q <= bus.src_sel;
               dst_q <= bus.dst_sel;
               if (!ok) begin
                  state   <= DONE;
                  bus.done <= 1'b1;
                  bus.err  <= 1'b1;
               end else if (bus.op == 2'b01) begin
                  state          <= WRITE;
                  xfer           <= bus.imm;
                  bus.data_bus   <= bus.imm;
                  bus.write_data <= NUM_REGS'(1) << bus.dst_sel;
               end else begin
                  state         <= READ;
                  bus.read_data <= NUM_REGS'(1) << bus.src_sel;
               end
            end
            READ: begin
               bus.read_data <= '0;
               state         <= CAPTURE;
            end
            // register output settled after the read strobe; latch it here
            CAPTURE: begin
               xfer <= slice;
               if (op_q == 2'b00) begin
                  state          <= WRITE;
                  bus.data_bus   <= slice;
                  bus.write_data <= NUM_REGS'(1) << dst_q;
               end else begin
                  state      <= DONE;
                  bus.result <= slice;
                  bus.done   <= 1'b1;
               end
            end
            WRITE: begin
               bus.write_data <= '0;
               bus.data_bus   <= '0;
               bus.result     <= xfer;
               bus.done       <= 1'b1;
               state          <= DONE;
            end
            DONE: begin
               bus.done <= 1'b0;
               bus.err  <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bus_transfer_controller.sv
// tb_bus_transfer_controller: table-driven transfers scored through an expectation queue
module tb_bus_transfer_controller;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;
   logic       start = 1'b0, start3 = 1'b0;
   logic [1:0] op = '0, src_sel = '0, dst_sel = '0;
   logic [7:0] imm = '0;
   logic [7:0] bank [4];
   localparam logic [7:0] INIT [4] = '{8'h11, 8'h3C, 8'h5A, 8'hC3};
   bus_transfer_if #(.NUM_REGS(4), .SEL_W(2), .DATA_W(8)) bus ();
   bus_transfer_if #(.NUM_REGS(3), .SEL_W(2), .DATA_W(8)) bus3 ();
   assign bus.start       = start;
   assign bus.op          = op;
   assign bus.src_sel     = src_sel;
   assign bus.dst_sel     = dst_sel;
   assign bus.imm         = imm;
   assign bus.reg_values  = {bank[3], bank[2], bank[1], bank[0]};
   assign bus3.start      = start3;
   assign bus3.op         = op;
   assign bus3.src_sel    = src_sel;
   assign bus3.dst_sel    = dst_sel;
   assign bus3.imm        = imm;
   assign bus3.reg_values = {bank[2], bank[1], bank[0]};
   bus_transfer_controller #(.NUM_REGS(4), .SEL_W(2), .DATA_W(8)) dut (.clock(clock), .reset(reset), .bus(bus.master));
   bus_transfer_controller #(.NUM_REGS(3), .SEL_W(2), .DATA_W(8)) dut3 (.clock(clock), .reset(reset), .bus(bus3.master));
   // register bank model driven by the write strobes
   always @(posedge clock) begin
      if (reset) for (int i = 0; i < 4; i++) bank[i] <= INIT[i];
      else for (int i = 0; i < 4; i++) if (bus.write_data[i]) bank[i] <= bus.data_bus;
   end
   int checks = 0, errors = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   always @(negedge clock) if (!reset) begin
      checks++;
      if (!$onehot0(bus.read_data) || !$onehot0(bus.write_data) || (|bus.read_data && |bus.write_data)
          || (bus.data_bus != 8'h00 && bus.write_data == 4'b0)) begin
         errors++;
         $display("FAIL strobe_rules: rd=%b wr=%b bus=%h", bus.read_data, bus.write_data, bus.data_bus);
      end
   end
   typedef struct {logic [1:0] op; logic [1:0] src; logic [1:0] dst; logic [7:0] imm; bit poke;} vec_t;
   typedef struct {int lat; int rdc; int wrc; logic err; logic [7:0] result; logic [7:0] bv; logic [3:0] rd; logic [3:0] wr;} exp_t;
   exp_t       sb [$];
   logic [7:0] exp_regs [4];
   logic [7:0] exp_last;
   vec_t       vecs [11];
   task automatic reset_model();
      for (int i = 0; i < 4; i++) exp_regs[i] = INIT[i];
      exp_last = 8'h00;
   endtask
   task automatic run_xfer(input vec_t v);
      exp_t e, g;
      e.err = v.op == 2'b11; e.rd = 0; e.wr = 0; e.bv = 0;
      case (v.op)
         2'b00: begin e.lat = 4; e.rd = 4'b1 << v.src; e.wr = 4'b1 << v.dst; e.bv = exp_regs[v.src]; e.result = exp_regs[v.src]; exp_regs[v.dst] = exp_regs[v.src]; end
         2'b01: begin e.lat = 2; e.wr = 4'b1 << v.dst; e.bv = v.imm; e.result = v.imm; exp_regs[v.dst] = v.imm; end
         2'b10: begin e.lat = 3; e.rd = 4'b1 << v.src; e.result = exp_regs[v.src]; end
         default: begin e.lat = 1; e.result = exp_last; end
      endcase
      e.rdc = e.rd != 0 ? 1 : 0;
      e.wrc = e.wr != 0 ? e.lat - 1 : 0;
      exp_last = e.result;
      sb.push_back(e);
      g.lat = 0; g.rdc = 0; g.wrc = 0; g.err = 0; g.result = 0; g.bv = 0; g.rd = 0; g.wr = 0;
      @(negedge clock);
      start = 1'b1; op = v.op; src_sel = v.src; dst_sel = v.dst; imm = v.imm;
      @(negedge clock);
      for (int c = 1; c <= 10 && g.lat == 0; c++) begin
         if (c > 1) @(negedge clock);
         if (c == 1) begin
            start = v.poke; op = v.poke ? 2'b01 : 2'($urandom);
            src_sel = 2'($urandom); dst_sel = 2'($urandom); imm = 8'($urandom);
         end else start = 1'b0;
         if (|bus.read_data) begin g.rd |= bus.read_data; g.rdc = c; end
         if (|bus.write_data) begin g.wr = bus.write_data; g.bv = bus.data_bus; g.wrc = c; end
         if (bus.done) begin g.lat = c; g.err = bus.err; g.result = bus.result; end
      end
      start = 1'b0;
      e = sb.pop_front();
      chk("latency", g.lat, e.lat);
      chk("err", 32'(g.err), 32'(e.err));
      chk("result", 32'(g.result), 32'(e.result));
      chk("read_strobe", {g.rd, 8'(g.rdc)}, {e.rd, 8'(e.rdc)});
      chk("write_strobe", {g.wr, 8'(g.wrc)}, {e.wr, 8'(e.wrc)});
      chk("write_bus", 32'(g.bv), 32'(e.bv));
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         chk("after_done", {bus.done, bus.busy, |bus.write_data, |bus.read_data, bus.err}, 0);
      end
   endtask
   task automatic run3(input logic [1:0] o, input logic [1:0] s, input logic [1:0] d, input logic [7:0] im,
                       input int elat, input logic eerr, input logic [2:0] ewr, input logic [7:0] eres);
      int lat = 0;
      logic [2:0] wr = 0, rd = 0;
      logic [7:0] res = 0, bv = 0;
      logic er = 0;
      @(negedge clock);
      start3 = 1'b1; op = o; src_sel = s; dst_sel = d; imm = im;
      @(negedge clock);
      start3 = 1'b0;
      for (int c = 1; c <= 8 && lat == 0; c++) begin
         if (c > 1) @(negedge clock);
         rd |= bus3.read_data;
         if (|bus3.write_data) begin wr = bus3.write_data; bv = bus3.data_bus; end
         if (bus3.done) begin lat = c; er = bus3.err; res = bus3.result; end
      end
      chk("n3_latency", lat, elat);
      chk("n3_err", 32'(er), 32'(eerr));
      chk("n3_strobes", {rd, wr}, {3'b000, ewr});
      chk("n3_bus", 32'(bv), ewr != 0 ? 32'(im) : 0);
      chk("n3_result", 32'(res), 32'(eres));
      @(negedge clock);
      chk("n3_after_done", {bus3.done, bus3.err, bus3.busy}, 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      vecs[0]  = '{2'b01, 2'd0, 2'd2, 8'hA5, 1'b0};
      vecs[1]  = '{2'b00, 2'd1, 2'd3, 8'h00, 1'b0};
      vecs[2]  = '{2'b10, 2'd0, 2'd1, 8'h00, 1'b1};
      vecs[3]  = '{2'b11, 2'd1, 2'd2, 8'h77, 1'b0};
      vecs[4]  = '{2'b00, 2'd2, 2'd2, 8'h00, 1'b0};
      vecs[5]  = '{2'b10, 2'd3, 2'd0, 8'h00, 1'b0};
      vecs[6]  = '{2'b01, 2'd2, 2'd1, 8'hFF, 1'b0};
      vecs[7]  = '{2'b00, 2'd1, 2'd0, 8'h00, 1'b0};
      vecs[8]  = '{2'b10, 2'd0, 2'd3, 8'h00, 1'b1};
      vecs[9]  = '{2'b10, 2'd2, 2'd0, 8'h00, 1'b0};
      vecs[10] = '{2'b11, 2'd3, 2'd3, 8'h42, 1'b0};
      reset_model();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("reset_outs", {bus.read_data, bus.write_data, bus.data_bus, bus.result, bus.busy, bus.done, bus.err}, 0);
      reset = 1'b0;
      repeat (5) begin
         @(negedge clock);
         chk("idle_outs", {bus.read_data, bus.write_data, bus.data_bus, bus.result, bus.busy, bus.done, bus.err}, 0);
      end
      run3(2'b01, 2'd0, 2'd3, 8'h99, 1, 1'b1, 3'b000, 8'h00);
      run3(2'b00, 2'd3, 2'd0, 8'h00, 1, 1'b1, 3'b000, 8'h00);
      run3(2'b01, 2'd0, 2'd2, 8'h77, 2, 1'b0, 3'b100, 8'h77);
      foreach (vecs[i]) run_xfer(vecs[i]);
      @(negedge clock);
      start = 1'b1; op = 2'b00; src_sel = 2'd1; dst_sel = 2'd3;
      @(negedge clock);
      start = 1'b0;
      chk("mid_read_strobe", bus.read_data, 4'b0010);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("mid_reset_outs", {bus.busy, bus.write_data, bus.read_data, bus.done, bus.err, bus.result}, 0);
      reset = 1'b0;
      reset_model();
      @(negedge clock);
      chk("post_reset_idle", {bus.busy, bus.write_data, bus.read_data, bus.done, bus.err}, 0);
      run_xfer('{2'b01, 2'd0, 2'd3, 8'h96, 1'b0});
      run_xfer('{2'b10, 2'd3, 2'd0, 8'h00, 1'b0});
      chk("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
